// File: rtl/bin_mult_pkg.sv
// bin_mult_pkg: register map, status/control bit positions and sequencer states for bin_mult_sched
package bin_mult_pkg;
    localparam logic [4:0] OFF_OP_LO  = 5'h00;
    localparam logic [4:0] OFF_OP_HI  = 5'h04;
    localparam logic [4:0] OFF_RESULT = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam int ST_BUSY    = 8;
    localparam int ST_OVF     = 9;
    localparam int ST_UDF     = 10;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_FLUSH = 2;
    localparam int RES_W      = 7;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a pop in the same cycle frees room so a push into a full FIFO is accepted
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop) rp <= rp + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/bin_mult_sched.sv
// bin_mult_sched: Wishbone job scheduler that feeds queued 64-bit operands to top_bin_mult
// and collects its 7-bit results into a FIFO for software to pop
module bin_mult_sched
    import bin_mult_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int DEPTH = 4,
    parameter int LATENCY = 2
) (
    input  logic             caravel_wb_clk_i,
    input  logic             caravel_wb_rst_i,
    input  logic             caravel_wb_stb_i,
    input  logic             caravel_wb_cyc_i,
    input  logic             caravel_wb_we_i,
    input  logic [3:0]       caravel_wb_sel_i,
    input  logic [31:0]      caravel_wb_adr_i,
    input  logic [31:0]      caravel_wb_dat_i,
    output logic             caravel_wb_ack_o,
    output logic [31:0]      caravel_wb_dat_o,
    output logic             mult_c_rst,
    output logic [31:0]      mult_data_low,
    output logic [31:0]      mult_data_high,
    input  logic [RES_W-1:0] mult_be_in,
    output logic             irq
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int AW = $clog2(DEPTH) + 1;
    logic clk, rst;
    logic [31:0] off, status, rdata, op_lo;
    logic [4:0] reg_off;
    logic hit, acc, wr, rd, flush, busy, unused;
    logic en, ie, ovf, udf;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic q_push, q_pop, q_full, q_empty, r_push, r_pop, r_full, r_empty, r_ok;
    logic [63:0] q_dout;
    logic [RES_W-1:0] r_dout, res;
    logic [AW-1:0] q_count, r_count;
    assign clk = caravel_wb_clk_i;
    assign rst = caravel_wb_rst_i;
    assign off = caravel_wb_adr_i - BASE_ADDRESS;
    assign reg_off = {off[4:2], 2'b00};
    assign hit = caravel_wb_stb_i & caravel_wb_cyc_i & (off[31:5] == '0);
    // one access per held strobe: the ack cycle itself never re-triggers
    assign acc = hit & ~caravel_wb_ack_o;
    assign wr = acc & caravel_wb_we_i;
    assign rd = acc & ~caravel_wb_we_i;
    assign flush = wr && reg_off == OFF_CTRL && caravel_wb_dat_i[CTRL_FLUSH];
    assign q_push = wr && reg_off == OFF_OP_HI;
    assign q_pop = state == IDLE && en && !q_empty && !flush;
    assign r_pop = rd && reg_off == OFF_RESULT;
    assign r_push = state == CAPTURE;
    assign r_ok = !r_full || r_pop;
    assign busy = state != IDLE;
    assign mult_c_rst = state == IDLE || state == LOAD;
    assign irq = ie && !r_empty;
    assign res = r_empty ? '0 : r_dout;
    assign unused = &{1'b0, caravel_wb_sel_i, off[1:0]};
    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_op_q (
        .clk(clk), .rst(rst), .flush(flush), .push(q_push), .pop(q_pop),
        .din({caravel_wb_dat_i, op_lo}), .dout(q_dout), .count(q_count),
        .full(q_full), .empty(q_empty)
    );
    sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_q (
        .clk(clk), .rst(rst), .flush(flush), .push(r_push), .pop(r_pop),
        .din(mult_be_in), .dout(r_dout), .count(r_count),
        .full(r_full), .empty(r_empty)
    );
    always_comb begin
        status = '0;
        status[3:0] = 4'(q_count);
        status[7:4] = 4'(r_count);
        status[ST_BUSY] = busy;
        status[ST_OVF] = ovf;
        status[ST_UDF] = udf;
    end
    assign rdata = reg_off == OFF_RESULT ? {25'b0, res} :
                   reg_off == OFF_STATUS ? status :
                   reg_off == OFF_CTRL   ? {30'b0, ie, en} : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = q_pop ? LOAD : IDLE;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = cnt == CW'(LATENCY - 1) ? CAPTURE : RUN;
            CAPTURE: state_nx = r_ok ? IDLE : CAPTURE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            caravel_wb_ack_o <= 1'b0;
            caravel_wb_dat_o <= '0;
            mult_data_low <= '0;
            mult_data_high <= '0;
            op_lo <= '0;
            cnt <= '0;
            {en, ie, ovf, udf} <= '0;
        end else begin
            caravel_wb_ack_o <= acc;
            caravel_wb_dat_o <= rd ? rdata : '0;
            cnt <= state == RUN ? cnt + CW'(1) : '0;
            if (q_pop) {mult_data_high, mult_data_low} <= q_dout;
            if (wr && reg_off == OFF_OP_LO) op_lo <= caravel_wb_dat_i;
            if (flush) op_lo <= '0;
            if (wr && reg_off == OFF_CTRL) begin
                en <= caravel_wb_dat_i[CTRL_EN];
                ie <= caravel_wb_dat_i[CTRL_IE];
            end
            if (q_push && q_full && !q_pop && !flush) ovf <= 1'b1;
            if (r_pop && r_empty) udf <= 1'b1;
            if (wr && reg_off == OFF_STATUS) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bin_mult_sched.sv
// tb_bin_mult_sched: randomized scenario bench for bin_mult_sched with a popcount datapath stub
module tb_bin_mult_sched;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int DEPTH = 4;
    localparam int LAT = 2;
    localparam logic [4:0] A_LO = 5'h00, A_HI = 5'h04, A_RES = 5'h08, A_ST = 5'h0C, A_CTRL = 5'h10;
    logic clk = 1'b0, rst = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0, rdat, lo, hi;
    logic ack, c_rst, irq;
    logic [6:0] be;
    int checks = 0, failures = 0;
    int exp_q[$];
    logic [31:0] q, dummy;

    always #5 clk = ~clk;

    // datapath stub: output is the popcount of the loaded operands while out of clear
    assign be = c_rst ? 7'd0 : 7'($countones({hi, lo}));

    bin_mult_sched #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .caravel_wb_clk_i(clk), .caravel_wb_rst_i(rst),
        .caravel_wb_stb_i(stb), .caravel_wb_cyc_i(cyc), .caravel_wb_we_i(we),
        .caravel_wb_sel_i(sel), .caravel_wb_adr_i(adr), .caravel_wb_dat_i(wdat),
        .caravel_wb_ack_o(ack), .caravel_wb_dat_o(rdat),
        .mult_c_rst(c_rst), .mult_data_low(lo), .mult_data_high(hi),
        .mult_be_in(be), .irq(irq)
    );

    function automatic logic [31:0] st(int qc, int rc, bit b, bit ov, bit ud);
        return {21'b0, ud, ov, b, 4'(rc), 4'(qc)};
    endfunction

    // returns 1ns after the edge at which the access took effect
    task automatic bus(input logic w, input logic [4:0] o, input logic [31:0] d, output logic [31:0] r);
        bit done = 0;
        r = '0;
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = BASE + 32'(o); wdat = d;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk); #1;
            if (ack) begin done = 1; r = rdat; end
        end
        stb = 0; cyc = 0; we = 0;
        checks++;
        if (!done) begin failures++; $display("FAIL bus_ack off=%0h got ack=0 want ack=1", o); end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] l, input logic [31:0] h);
        bus(1, A_LO, l, dummy);
        bus(1, A_HI, h, dummy);
    endtask

    task automatic test_reset;
        rst = 1;
        cycles(3);
        checks++; if (c_rst !== 1'b1) begin failures++; $display("FAIL reset_c_rst got=%b want=1", c_rst); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
        checks++; if (ack !== 1'b0 || rdat !== 32'h0) begin failures++; $display("FAIL reset_bus got ack=%b dat=%h want 0/0", ack, rdat); end
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_data got=%h want=0", {hi, lo}); end
        rst = 0;
        bus(0, A_ST, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL reset_status got=%h want=0", q); end
    endtask

    task automatic test_single_job;
        int lows = 0;
        bus(1, A_CTRL, 32'h3, dummy);
        bus(0, A_CTRL, 0, q);
        checks++; if (q !== 32'h3) begin failures++; $display("FAIL ctrl_readback got=%h want=3", q); end
        push_job(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF || c_rst !== 1'b1) begin
                    failures++; $display("FAIL load_data got data=%h c_rst=%b want all-ones/1", {hi, lo}, c_rst); end
            end
            if (!c_rst) lows++;
            if (k == LAT + 2) begin
                checks++; if (irq !== 1'b0) begin failures++; $display("FAIL job_early got irq=%b want=0", irq); end
            end
            if (k == LAT + 3) begin
                checks++; if (irq !== 1'b1) begin failures++; $display("FAIL job_latency got irq=%b want=1", irq); end
            end
        end
        checks++; if (lows != LAT + 1) begin failures++; $display("FAIL c_rst_low got=%0d want=%0d", lows, LAT + 1); end
        bus(0, A_RES, 0, q);
        checks++; if (q !== 32'd64) begin failures++; $display("FAIL result_64 got=%h want=%h", q, 32'd64); end
        bus(0, A_ST, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL status_after_pop got=%h want=0", q); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_pop got=%b want=0", irq); end
    endtask

    task automatic test_overflow_order;
        logic [31:0] l, h;
        bus(1, A_CTRL, 32'h0, dummy);
        for (int i = 0; i < DEPTH + 1; i++) begin
            l = $urandom; h = $urandom;
            push_job(l, h);
            if (i < DEPTH) exp_q.push_back($countones({h, l}));
        end
        bus(0, A_ST, 0, q);
        checks++; if (q !== st(DEPTH, 0, 0, 1, 0)) begin failures++; $display("FAIL overflow_status got=%h want=%h", q, st(DEPTH, 0, 0, 1, 0)); end
        bus(1, A_CTRL, 32'h1, dummy);
        cycles(DEPTH * (LAT + 3) + 8);
        bus(0, A_ST, 0, q);
        checks++; if (q !== st(0, DEPTH, 0, 1, 0)) begin failures++; $display("FAIL drained_status got=%h want=%h", q, st(0, DEPTH, 0, 1, 0)); end
        for (int i = 0; i < DEPTH; i++) begin
            bus(0, A_RES, 0, q);
            checks++; if (q !== 32'(exp_q[0])) begin failures++; $display("FAIL order_%0d got=%h want=%h", i, q, 32'(exp_q[0])); end
            void'(exp_q.pop_front());
        end
        bus(1, A_ST, 32'h0, dummy);
        bus(0, A_ST, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL sticky_clear got=%h want=0", q); end
    endtask

    task automatic test_backpressure;
        logic [31:0] l, h;
        bus(1, A_CTRL, 32'h1, dummy);
        for (int i = 0; i < DEPTH; i++) begin
            l = $urandom; h = $urandom;
            push_job(l, h);
            exp_q.push_back($countones({h, l}));
        end
        cycles(DEPTH * (LAT + 3) + 8);
        l = $urandom; h = $urandom;
        push_job(l, h);
        exp_q.push_back($countones({h, l}));
        cycles(LAT + 8);
        bus(0, A_ST, 0, q);
        checks++; if (q !== st(0, DEPTH, 1, 0, 0)) begin failures++; $display("FAIL held_capture got=%h want=%h", q, st(0, DEPTH, 1, 0, 0)); end
        for (int i = 0; i <= DEPTH; i++) begin
            bus(0, A_RES, 0, q);
            checks++; if (q !== 32'(exp_q[0])) begin failures++; $display("FAIL bp_order_%0d got=%h want=%h", i, q, 32'(exp_q[0])); end
            void'(exp_q.pop_front());
            if (i == 0) begin
                cycles(4);
                bus(0, A_ST, 0, q);
                checks++; if (q !== st(0, DEPTH, 0, 0, 0)) begin failures++; $display("FAIL capture_released got=%h want=%h", q, st(0, DEPTH, 0, 0, 0)); end
            end
        end
    endtask

    task automatic test_underflow;
        bus(0, A_RES, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL underflow_data got=%h want=0", q); end
        bus(1, 5'h18, 32'hDEAD_BEEF, dummy);
        bus(0, 5'h18, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h want=0", q); end
        bus(0, A_ST, 0, q);
        checks++; if (q !== st(0, 0, 0, 0, 1)) begin failures++; $display("FAIL underflow_status got=%h want=%h", q, st(0, 0, 0, 0, 1)); end
        bus(1, A_ST, 32'hFFFF_FFFF, dummy);
        bus(0, A_ST, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL underflow_clear got=%h want=0", q); end
    endtask

    task automatic test_flush;
        logic [31:0] x;
        bus(1, A_CTRL, 32'h3, dummy);
        push_job($urandom, $urandom);
        cycles(LAT + 6);
        push_job($urandom, $urandom);
        push_job($urandom, $urandom);
        @(posedge clk);
        bus(1, A_CTRL, 32'h7, dummy);
        checks++; if (c_rst !== 1'b1 || irq !== 1'b0) begin failures++; $display("FAIL flush_outputs got c_rst=%b irq=%b want 1/0", c_rst, irq); end
        bus(0, A_ST, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL flush_status got=%h want=0", q); end
        x = $urandom;
        bus(1, A_HI, x, dummy);
        cycles(1);
        checks++; if ({hi, lo} !== {x, 32'h0}) begin failures++; $display("FAIL flush_staged got=%h want=%h", {hi, lo}, {x, 32'h0}); end
        cycles(LAT + 4);
        bus(0, A_RES, 0, q);
        checks++; if (q !== 32'($countones(x))) begin failures++; $display("FAIL flush_result got=%h want=%h", q, 32'($countones(x))); end
    endtask

    task automatic test_reset_mid_run;
        bus(1, A_CTRL, 32'h3, dummy);
        push_job($urandom, $urandom);
        cycles(2);
        checks++; if (c_rst !== 1'b0) begin failures++; $display("FAIL pre_reset_run got c_rst=%b want=0", c_rst); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        checks++; if (c_rst !== 1'b1 || irq !== 1'b0 || ack !== 1'b0 || rdat !== 32'h0 || {hi, lo} !== 64'h0) begin
            failures++; $display("FAIL midrun_reset got c_rst=%b irq=%b ack=%b dat=%h data=%h", c_rst, irq, ack, rdat, {hi, lo}); end
        rst = 0;
        cycles(LAT + 5);
        bus(0, A_ST, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL midrun_status got=%h want=0", q); end
        bus(0, A_CTRL, 0, q);
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL midrun_ctrl got=%h want=0", q); end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_overflow_order();
        test_backpressure();
        test_underflow();
        test_flush();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
